// File: rtl/card7_pkg.sv
// Shared card / 7-segment definitions for the card display encoder and decoder.
// Segment patterns are active-low, bit order {g,f,e,d,c,b,a}.
package card7_pkg;

  typedef logic [3:0] card_t;
  typedef logic [6:0] seg_t;

  localparam seg_t SEG_BLANK = 7'b1111111;
  localparam seg_t SEG_ACE   = 7'b0001000;
  localparam seg_t SEG_TWO   = 7'b0100100;
  localparam seg_t SEG_THREE = 7'b0110000;
  localparam seg_t SEG_FOUR  = 7'b0011001;
  localparam seg_t SEG_FIVE  = 7'b0010010;
  localparam seg_t SEG_SIX   = 7'b0000010;
  localparam seg_t SEG_SEVEN = 7'b1111000;
  localparam seg_t SEG_EIGHT = 7'b0000000;
  localparam seg_t SEG_NINE  = 7'b0010000;
  localparam seg_t SEG_TEN   = 7'b1000000;
  localparam seg_t SEG_JACK  = 7'b1100001;
  localparam seg_t SEG_QUEEN = 7'b0011000;
  localparam seg_t SEG_KING  = 7'b0001001;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_ACCEPT
  } state_e;

  // Result of looking up one segment pattern.
  typedef struct packed {
    logic  legal;
    card_t card;
    logic [3:0] value;
  } dec_t;

  // Baccarat points: ace counts 1, pips 2..9 count face, tens/faces/blank 0.
  function automatic logic [3:0] baccarat_value(card_t c);
    return (c >= 4'd1 && c <= 4'd9) ? c : 4'd0;
  endfunction

endpackage

// File: rtl/seg7_to_card.sv
// Combinational lookup: active-low segment pattern -> {legal, card, value}.
module seg7_to_card
  import card7_pkg::*;
(
  input  seg_t pat_i,
  output dec_t dec_o
);

  // Match against the 14 shared patterns; anything else is illegal.
  always_comb begin
    dec_o.legal = 1'b1;
    dec_o.card  = 4'd0;
    case (pat_i)
      SEG_BLANK: dec_o.card = 4'd0;
      SEG_ACE:   dec_o.card = 4'd1;
      SEG_TWO:   dec_o.card = 4'd2;
      SEG_THREE: dec_o.card = 4'd3;
      SEG_FOUR:  dec_o.card = 4'd4;
      SEG_FIVE:  dec_o.card = 4'd5;
      SEG_SIX:   dec_o.card = 4'd6;
      SEG_SEVEN: dec_o.card = 4'd7;
      SEG_EIGHT: dec_o.card = 4'd8;
      SEG_NINE:  dec_o.card = 4'd9;
      SEG_TEN:   dec_o.card = 4'd10;
      SEG_JACK:  dec_o.card = 4'd11;
      SEG_QUEEN: dec_o.card = 4'd12;
      SEG_KING:  dec_o.card = 4'd13;
      default:   dec_o.legal = 1'b0;
    endcase
    dec_o.value = baccarat_value(dec_o.card);
  end

endmodule

// File: rtl/seg7_card_decoder.sv
// Glitch-filtered 7-segment -> card decoder with accept strobe and
// sticky illegal-pattern flag.
module seg7_card_decoder
  import card7_pkg::*;
#(
  parameter int STABLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       resetb,
  input  logic [6:0] hex_in,
  output logic [3:0] card,
  output logic [3:0] card_value,
  output logic       card_strobe,
  output logic       blank,
  output logic       pattern_err
);

  localparam int             CNT_W   = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);

  seg_t             samp_q, prev_q, acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  state_e           state_q, state_d;
  card_t            card_q, card_d;
  logic [3:0]       value_q, value_d;
  logic             strobe_q, strobe_d;
  logic             blank_q, blank_d;
  logic             err_q, err_d;
  dec_t             dec;

  seg7_to_card u_lut (
    .pat_i (samp_q),
    .dec_o (dec)
  );

  // Run length of the current sample value, saturating at the threshold.
  always_comb begin
    cnt_d = cnt_q;
    if (samp_q != prev_q)      cnt_d = CNT_W'(1);
    else if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
  end

  // Input synchroniser/history and stability counter.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      samp_q <= SEG_BLANK;
      prev_q <= SEG_BLANK;
      cnt_q  <= '0;
    end else begin
      samp_q <= hex_in;
      prev_q <= samp_q;
      cnt_q  <= cnt_d;
    end
  end

  // Next state and output values. The accepted pattern and outputs are
  // committed on the edge that enters ACCEPT, so they are already valid
  // during the one ACCEPT cycle; ACCEPT itself only spaces out strobes.
  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    card_d   = card_q;
    value_d  = value_q;
    blank_d  = blank_q;
    err_d    = err_q;
    strobe_d = 1'b0;
    case (state_q)
      ST_IDLE:
        if (samp_q != acc_q) state_d = ST_SETTLE;
      ST_SETTLE:
        // A fresh change restarts the count even if the old count was full.
        if (samp_q == prev_q && cnt_q == CNT_MAX) begin
          if (samp_q == acc_q) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_ACCEPT;
            acc_d   = samp_q;
            if (dec.legal) begin
              card_d   = dec.card;
              value_d  = dec.value;
              blank_d  = (dec.card == 4'd0);
              err_d    = 1'b0;
              strobe_d = 1'b1;
            end else begin
              err_d    = 1'b1;
            end
          end
        end
      ST_ACCEPT:
        state_d = ST_IDLE;
      default:
        state_d = ST_IDLE;
    endcase
  end

  // FSM and registered outputs.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      state_q  <= ST_IDLE;
      acc_q    <= SEG_BLANK;
      card_q   <= 4'd0;
      value_q  <= 4'd0;
      blank_q  <= 1'b1;
      err_q    <= 1'b0;
      strobe_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      card_q   <= card_d;
      value_q  <= value_d;
      blank_q  <= blank_d;
      err_q    <= err_d;
      strobe_q <= strobe_d;
    end
  end

  assign card        = card_q;
  assign card_value  = value_q;
  assign card_strobe = strobe_q;
  assign blank       = blank_q;
  assign pattern_err = err_q;

endmodule

// File: tb/tb_seg7_card_decoder.sv
// Directed + randomised bench for seg7_card_decoder (STABLE_CYCLES 4 and 1).
module tb_seg7_card_decoder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       resetb;
  logic [6:0] hex4, hex1;
  logic [3:0] card4, val4, card1, val1;
  logic       stb4, blank4, err4, stb1, blank1, err1;

  seg7_card_decoder #(.STABLE_CYCLES(4)) dut4 (
    .clk(clk), .resetb(resetb), .hex_in(hex4), .card(card4), .card_value(val4),
    .card_strobe(stb4), .blank(blank4), .pattern_err(err4)
  );

  seg7_card_decoder #(.STABLE_CYCLES(1)) dut1 (
    .clk(clk), .resetb(resetb), .hex_in(hex1), .card(card1), .card_value(val1),
    .card_strobe(stb1), .blank(blank1), .pattern_err(err1)
  );

  // Independent encoder table, index = card code (0 = blank).
  logic [6:0] seg_tab [14] = '{
    7'b1111111, 7'b0001000, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000,
    7'b1000000, 7'b1100001, 7'b0011000, 7'b0001001
  };

  int n_assert = 0, n_fail = 0;
  int s4 = 0, s1 = 0, dbl = 0;
  logic prev4 = 1'b0, prev1 = 1'b0;

  // Strobe counters and back-to-back strobe detector.
  always @(negedge clk) begin
    if (stb4 === 1'b1) s4 <= s4 + 1;
    if (stb1 === 1'b1) s1 <= s1 + 1;
    if ((stb4 === 1'b1 && prev4 === 1'b1) || (stb1 === 1'b1 && prev1 === 1'b1)) dbl <= dbl + 1;
    prev4 <= stb4;
    prev1 <= stb1;
  end

  function automatic int bval(input int c);
    return (c >= 1 && c <= 9) ? c : 0;
  endfunction

  function automatic int find_card(input logic [6:0] p);
    for (int i = 0; i < 14; i++) if (seg_tab[i] == p) return i;
    return -1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic chk4(input string tag, input int c, input int v, input int b, input int e, input int s);
    chk({tag, ".card"},  card4,  c);
    chk({tag, ".value"}, val4,   v);
    chk({tag, ".blank"}, blank4, b);
    chk({tag, ".err"},   err4,   e);
    chk({tag, ".nstb"},  s4,     s);
  endtask

  logic [6:0] pat, prevpat, macc;
  int mcard, mval, mblank, merr, mstr, len, idx;
  logic lng;

  initial begin
    resetb = 1'b0; hex4 = 7'h7F; hex1 = 7'h7F;
    step(2);
    chk("rst.strobe", stb4, 0);
    chk4("rst", 0, 0, 1, 0, 0);
    resetb = 1'b1;
    step(2);

    // 1: card 2, exact latency
    hex4 = seg_tab[2];
    step(5);
    chk("t1.early_strobe", stb4, 0);
    step(1);
    chk("t1.strobe", stb4, 1);
    chk4("t1", 2, 2, 0, 0, 1);
    step(1);
    chk("t1.strobe_drop", stb4, 0);

    // 2: short K glitch then back to 2
    hex4 = seg_tab[13]; step(3);
    hex4 = seg_tab[2];  step(10);
    chk4("t2", 2, 2, 0, 0, 1);

    // 3: Jack, then blank
    hex4 = seg_tab[11]; step(8);
    chk4("t3j", 11, 0, 0, 0, 2);
    hex4 = seg_tab[0];  step(8);
    chk4("t3b", 0, 0, 1, 0, 3);

    // 4: illegal pattern, then Ace
    hex4 = 7'b0101010;  step(8);
    chk4("t4i", 0, 0, 1, 1, 3);
    hex4 = seg_tab[1];  step(8);
    chk4("t4a", 1, 1, 0, 0, 4);

    // 5: reset in the middle of settling on 8
    hex4 = seg_tab[8];  step(3);
    resetb = 1'b0; #1;
    chk("t5.rst_strobe", stb4, 0);
    chk4("t5rst", 0, 0, 1, 0, 4);
    step(1);
    resetb = 1'b1;
    for (int i = 0; i < 20 && s4 == 4; i++) step(1);
    chk4("t5", 8, 8, 0, 0, 5);

    // 6: STABLE_CYCLES=1 walk of every card then blank
    for (int i = 1; i <= 14; i++) begin
      idx = i % 14;
      hex1 = seg_tab[idx];
      step(3);
      chk("t6.nstb",  s1,    i);
      chk("t6.card",  card1, idx);
      chk("t6.value", val1,  bval(idx));
      chk("t6.blank", blank1, (idx == 0) ? 1 : 0);
      chk("t6.err",   err1,  0);
    end

    // Random runs on the 4-cycle instance against a run-length model:
    // a run of >= STABLE_CYCLES+1 samples differing from the accepted
    // pattern is accepted; shorter runs leave everything untouched.
    macc = seg_tab[8]; mcard = 8; mval = 8; mblank = 0; merr = 0; mstr = s4;
    prevpat = macc;
    for (int r = 0; r < 40; r++) begin
      do begin
        if ($urandom_range(0, 1) == 1) pat = seg_tab[$urandom_range(0, 13)];
        else                           pat = 7'($urandom);
      end while (pat == prevpat);
      lng = ($urandom_range(0, 1) == 1);
      len = lng ? $urandom_range(7, 10) : $urandom_range(1, 3);
      hex4 = pat;
      step(len);
      if (lng && pat != macc) begin
        macc = pat;
        idx  = find_card(pat);
        if (idx >= 0) begin
          mcard = idx; mval = bval(idx); mblank = (idx == 0) ? 1 : 0; merr = 0; mstr++;
        end else begin
          merr = 1;
        end
      end
      chk4("rnd", mcard, mval, mblank, merr, mstr);
      prevpat = pat;
    end

    chk("strobe_back_to_back", dbl, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
